// File: rtl/pio_pkg.sv
// pio_pkg: shared offset map and offset field type for the parallel I/O bank.
package pio_pkg;

    // Offset field within the 16-byte I/O window (address[3:0]).
    typedef logic [3:0] pio_off_t;

    localparam pio_off_t OFF_OUT0   = 4'd0;
    localparam pio_off_t OFF_IN0    = 4'd8;
    localparam pio_off_t OFF_STATUS = 4'd14;
    localparam pio_off_t OFF_MASK   = 4'd15;

endpackage

// File: rtl/pio_in_channel.sv
// pio_in_channel: one asynchronous input channel.
// Two synchroniser flops feed a stable register. The optional debounce filter
// is enabled with the PIO_DEBOUNCE_EN macro. The change output is a combinational
// pulse. It is high during the cycle before the edge on which stable loads a
// new value, so the top-level flag sets on that same edge.
module pio_in_channel #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] stable,
    output logic         change
);

    logic [N-1:0] sync1_reg;
    logic [N-1:0] sync2_reg;
    logic [N-1:0] stable_reg;
    logic         stable_load;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;

    // A new value is accepted after DEBOUNCE_CYCLES consecutive differing edges.
    assign stable_load = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);

    // The count runs while sync2 differs from stable. It restarts on any return to the stable value or on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if ((sync2_reg == stable_reg) || stable_load) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
`else
    // Without debounce, stable simply tracks sync2 one cycle later.
    assign stable_load = (sync2_reg != stable_reg);
`endif

    // Stable register; loads only when the synchronised value is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_reg <= '0;
        end else if (stable_load) begin
            stable_reg <= sync2_reg;
        end
    end

    assign stable = stable_reg;
    assign change = stable_load;

endmodule

// File: rtl/parallel_io_bank.sv
// parallel_io_bank: memory-mapped output registers, synchronised inputs,
// change flags with write-1-to-clear, interrupt mask and registered irq.
// The per-channel debounce filter is enabled by defining PIO_DEBOUNCE_EN.
module parallel_io_bank
    import pio_pkg::*;
#(
    parameter int             N               = 8,
    parameter int             NUM_OUT         = 4,
    parameter int             NUM_IN          = 2,
    parameter logic [N-1:0]   BASE_ADDR       = 'hF0,
    parameter int             DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [N-1:0]          address,
    input  logic [N-1:0]          wdata,
    input  logic [N-1:0]          mem_rdata,
    input  logic [NUM_IN*N-1:0]   din,
    output logic                  ram_wren,
    output logic [N-1:0]          rdata,
    output logic [NUM_OUT*N-1:0]  dout,
    output logic                  irq
);

    logic        io_hit;
    logic        io_wr;
    pio_off_t    offset;

    assign io_hit   = (address[N-1:4] == BASE_ADDR[N-1:4]);
    assign offset   = address[3:0];
    assign io_wr    = we & io_hit;
    assign ram_wren = we & ~io_hit;

    // ---------------- output registers ----------------
    logic [N-1:0] dout_reg [NUM_OUT];

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
        // Output register gi is written by a store to its offset.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_reg[gi] <= '0;
            end else if (io_wr && (offset == pio_off_t'(OFF_OUT0 + gi))) begin
                dout_reg[gi] <= wdata;
            end
        end
        assign dout[gi*N +: N] = dout_reg[gi];
    end

    // ---------------- input channels ----------------
    logic [N-1:0]      stable_arr [NUM_IN];
    logic [NUM_IN-1:0] change_vec;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        pio_in_channel #(
            .N               (N),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .din    (din[gi*N +: N]),
            .stable (stable_arr[gi]),
            .change (change_vec[gi])
        );
    end

    // ---------------- flags, mask, irq ----------------
    logic [NUM_IN-1:0] flags_reg;
    logic [NUM_IN-1:0] flags_next;
    logic [NUM_IN-1:0] mask_reg;
    logic [NUM_IN-1:0] mask_next;
    logic              irq_reg;

    // Next-state flags and mask. A new change is OR-ed in after the W1C, so a set beats a clear.
    always_comb begin
        flags_next = flags_reg;
        mask_next  = mask_reg;
        if (io_wr && (offset == OFF_STATUS)) begin
            flags_next = flags_reg & ~wdata[NUM_IN-1:0];
        end
        flags_next = flags_next | change_vec;
        if (io_wr && (offset == OFF_MASK)) begin
            mask_next = wdata[NUM_IN-1:0];
        end
    end

    // irq is registered from the next-state values so it moves on the same edge as the flag or mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_reg <= '0;
            mask_reg  <= '0;
            irq_reg   <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            mask_reg  <= mask_next;
            irq_reg   <= |(flags_next & mask_next);
        end
    end

    assign irq = irq_reg;

    // ---------------- read mux ----------------
    logic [N-1:0] rd_io;

    // Combinational decode of the I/O window. Unmapped offsets read zero, and non-I/O addresses pass RAM data through.
    always_comb begin
        rd_io = '0;
        if (offset == OFF_STATUS) begin
            rd_io = N'(flags_reg);
        end else if (offset == OFF_MASK) begin
            rd_io = N'(mask_reg);
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            if (offset == pio_off_t'(OFF_OUT0 + k)) begin
                rd_io = dout_reg[k];
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (offset == pio_off_t'(OFF_IN0 + k)) begin
                rd_io = stable_arr[k];
            end
        end
        rdata = io_hit ? rd_io : mem_rdata;
    end

endmodule

// File: doc/parallel_io_bank.md
# parallel_io_bank

Memory-mapped parallel I/O bank for the single-cycle processor's data bus. It generalises the fixed one-port ParallelOut/ParallelIn pair into NUM_OUT write-back output registers and NUM_IN synchronised input channels. It adds per-input change flags, an interrupt mask and optional debouncing. It sits between the ALU-result/rd2 data path and RamDataMem: it steers RAM write enable and selects the read data returned to the register file.

## Interface
Parameters:
- N, 8: data and address width.
- NUM_OUT, 4: output registers, 1..8.
- NUM_IN, 2: input channels, 1..6.
- BASE_ADDR, 8'hF0: bank base address; low 4 bits must be 0.
- DEBOUNCE_CYCLES, 16: stability window, ≥1. Used only with PIO_DEBOUNCE_EN.

Ports:
- clk  in  1  processor clock. One clock only; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- we  in  1  MemWrite from the control unit.
- address  in  N  ALU result, used as the bus address.
- wdata  in  N  store data (rd2).
- mem_rdata  in  N  RamDataMem q.
- din  in  NUM_IN*N  asynchronous input channels; channel k is bits [k*N +: N].
- ram_wren  out  1  we & ~io_hit.
- rdata  out  N  load data to the MemtoReg mux.
- dout  out  NUM_OUT*N  output registers; channel k is bits [k*N +: N].
- irq  out  1  |(flags & mask), registered.

## Operation
- io_hit = (address[N-1:4] == BASE_ADDR[N-1:4]). The offset is address[3:0].
- Offset map:
  - 0..NUM_OUT-1: output register k, read/write.
  - 8..8+NUM_IN-1: stable input k, read-only.
  - 14: STATUS, flags in bits [NUM_IN-1:0], write-1-to-clear.
  - 15: MASK, bits [NUM_IN-1:0], read/write.
  - Any other offset reads 0; writes to it are ignored.
- rdata is combinational. It is the decoded register when io_hit=1, otherwise mem_rdata. Bits above NUM_IN in STATUS and MASK read as 0.
- Writes occur on the clk edge when we & io_hit. ram_wren is low for every I/O address.
- Each input channel has two synchroniser flops (sync1, sync2) feeding a stable register.
- flag[k] sets on any edge where stable[k] changes value.
- When a set and a W1C clear hit the same flag on the same edge, the set wins.
- Reset values:
  - dout, mask, flags, stable, sync flops and irq are all 0.
  - rdata follows the combinational decode rule above.
  - ram_wren = we & ~io_hit.
- rst asserted mid-operation overrides any write on the same edge.

## Timing
- Output write: a store at edge t makes dout valid after edge t. Zero wait states.
- Input path without debounce: din sampled at edge t → sync2 at t+1 → stable and flag updated at t+2. Read data changes after t+2.
- irq is registered from the next-state flags and mask, so it asserts on the same edge as the flag.
- A MASK write at edge t takes effect on irq at edge t.
- A W1C at edge t deasserts irq at edge t, unless another unmasked flag is set.
- Input glitches shorter than one clk period may be missed. This is accepted behaviour.

## Configuration
- PIO_DEBOUNCE_EN defined:
  - Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets to 0 whenever sync2 == stable.
  - On edges where sync2 != stable, the counter increments.
  - On the edge where the counter reaches DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2, the counter clears and the flag sets.
  - stable therefore updates at edge t+1+DEBOUNCE_CYCLES for a change sampled at edge t.
  - Any bounce back to the old value restarts the count.
- PIO_DEBOUNCE_EN undefined: stable <= sync2 every cycle and no counter is synthesised. Behaviour is identical to DEBOUNCE_CYCLES=1.

## Structure
- Package pio_pkg holds:
  - offset constants: OFF_OUT0=0, OFF_IN0=8, OFF_STATUS=14, OFF_MASK=15;
  - a typedef for the offset field (logic [3:0]).
- Sub-module pio_in_channel, instantiated NUM_IN times by a generate loop, contains synchroniser, optional debounce and change detect. It outputs stable[N-1:0] and a one-cycle change pulse.
- Decode, output registers, flags, mask and irq live in the top module.

## Test plan
- Reset: assert rst with we=1, address=8'hF0, wdata=8'hAA → dout=0, irq=0, and the write is ignored.
- Output write/readback: we=1, address=8'hF2, wdata=8'h5C → dout[23:16]=8'h5C after the edge, ram_wren=0. Then address=8'hF2 with we=0 → rdata=8'h5C.
- RAM passthrough: address=8'h10, we=1, mem_rdata=8'h33 → ram_wren=1, rdata=8'h33, dout unchanged.
- Input change without debounce: din[7:0] goes 0→8'h81 and MASK=1 → stable reads 8'h81 and STATUS=1 after 2 edges, with irq=1 on that edge. Writing 8'h01 to 8'hFE clears the flag and irq.
- Set-vs-clear collision: a W1C to STATUS on the same edge a new change lands → flag remains 1.
- Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): a 3-cycle pulse → no stable change and no flag. A held level → stable updates at edge t+5.
